// File: rtl/multiboot_icap_seq.sv
// Spartan-6 multiboot sequencer: emits the ICAP warm-boot command stream for a
// selectable SPI slot, from a level request or a debounced reset-button release.
module multiboot_icap_seq #(
    parameter int          NUM_SLOTS   = 4,
    parameter int          SLOT_W      = 2,
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter logic [23:0] SLOT_STRIDE = 24'h060000,
    parameter int          READ_MODE   = 2,
    parameter int          GAP_CYCLES  = 0,
    parameter int          HOLD_CYCLES = 16,
    parameter int          BTN_SLOT    = 0
) (
    input  logic              CLK,
    input  logic              MBT_RESET,
    input  logic              reboot_req,
    input  logic [SLOT_W-1:0] reboot_slot,
    input  logic              btn_n,
    output logic              busy,
    output logic              err,
    output logic              icap_ce_n,
    output logic              icap_wr_n,
    output logic [15:0]       icap_i
);

    localparam int                NUM_WORDS = (READ_MODE == 2) ? 16 : 14;
    localparam logic [3:0]        LAST_K    = 4'(NUM_WORDS - 1);
    localparam logic [3:0]        GAP_LAST  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam int                CNT_W     = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [SLOT_W-1:0] BTN_SEL   = SLOT_W'(BTN_SLOT);
    localparam logic [7:0]        OPCODE    = (READ_MODE == 2) ? 8'h6B :
                                              (READ_MODE == 1) ? 8'h3B : 8'h03;

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_WORD, S_GAP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          k_q, k_d;
    logic [3:0]          gap_q, gap_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [23:0]         addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                ce_n_q, ce_n_d;
    logic [15:0]         icap_q, icap_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                btn_trig;
    logic                slot_ok;

    // Without the MODE write the list skips two entries after the read opcode.
    function automatic logic [15:0] word_at(input logic [3:0] k, input logic [23:0] addr);
        logic [3:0] idx;
        idx = (READ_MODE != 2 && k >= 4'd8) ? k + 4'd2 : k;
        case (idx)
            4'd0:    return 16'hAA99;
            4'd1:    return 16'h5566;
            4'd2:    return 16'h30A1;
            4'd3:    return 16'h0000;
            4'd4:    return 16'h3261;
            4'd5:    return addr[15:0];
            4'd6:    return 16'h3281;
            4'd7:    return {OPCODE, addr[23:16]};
            4'd8:    return 16'h3301;
            4'd9:    return 16'h3100;
            4'd10:   return 16'h30A1;
            4'd11:   return 16'h000E;
            default: return 16'h2000;
        endcase
    endfunction

    function automatic logic [15:0] rev_bytes(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8 + i] = w[15-i];
        end
        return r;
    endfunction

    assign btn_trig = sync2_q && (cnt_q == HOLD_MAX);
    assign slot_ok  = int'(reboot_slot) < NUM_SLOTS;

    always_comb begin
        // NOTE: every _d takes its hold value first so no branch can infer a latch.
        state_d = state_q;
        k_d     = k_q;
        gap_d   = gap_q;
        slot_d  = slot_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!busy_q) begin
                    if (reboot_req) begin
                        if (slot_ok) begin
                            slot_d  = reboot_slot;
                            state_d = S_LATCH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (btn_trig) begin
                        slot_d  = BTN_SEL;
                        state_d = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                addr_d  = BASE_ADDR + 24'(slot_q) * SLOT_STRIDE;
                k_d     = 4'd0;
                state_d = S_WORD;
            end
            S_WORD: begin
                if (GAP_CYCLES > 0) begin
                    gap_d   = 4'd0;
                    state_d = S_GAP;
                end else if (k_q == LAST_K) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (k_q == LAST_K) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 4'd1;
                        state_d = S_WORD;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pins are registered one cycle behind the FSM; busy spans that extra stage
    // so it falls only once the DONE cycle has shown on the pins.
    always_comb begin
        busy_d  = (state_d != S_IDLE) || (state_q != S_IDLE);
        ce_n_d  = (state_q != S_WORD);
        icap_d  = (state_q == S_WORD) ? rev_bytes(word_at(k_q, addr_q)) : 16'hFFFF;
        sync1_d = btn_n;
        sync2_d = sync1_q;
        if (sync2_q)
            cnt_d = '0;
        else
            cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
        if (MBT_RESET) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
            gap_q   <= 4'd0;
            slot_q  <= '0;
            addr_q  <= 24'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            icap_q  <= 16'hFFFF;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            gap_q   <= gap_d;
            slot_q  <= slot_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ce_n_q  <= ce_n_d;
            icap_q  <= icap_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign err       = err_q;
    assign icap_ce_n = ce_n_q;
    assign icap_wr_n = ce_n_q;
    assign icap_i    = icap_q;

endmodule

// File: tb/tb_multiboot_icap_seq.sv
// Bench for multiboot_icap_seq: two configurations checked cycle by cycle against
// a timeline model of the command stream, plus literal spot checks.
module tb_multiboot_icap_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [2];
    logic [1:0]  slot  [2];
    logic        btn   [2];
    logic        busy  [2];
    logic        err   [2];
    logic        ce_n  [2];
    logic        wr_n  [2];
    logic [15:0] ii    [2];

    int checks = 0;
    int errors = 0;

    always #25 clk = ~clk;

    multiboot_icap_seq #(
        .NUM_SLOTS(4), .SLOT_W(2), .BASE_ADDR(24'h000000), .SLOT_STRIDE(24'h060000),
        .READ_MODE(2), .GAP_CYCLES(0), .HOLD_CYCLES(16), .BTN_SLOT(0)
    ) dut0 (
        .CLK(clk), .MBT_RESET(rst), .reboot_req(req[0]), .reboot_slot(slot[0]),
        .btn_n(btn[0]), .busy(busy[0]), .err(err[0]), .icap_ce_n(ce_n[0]),
        .icap_wr_n(wr_n[0]), .icap_i(ii[0])
    );

    multiboot_icap_seq #(
        .NUM_SLOTS(3), .SLOT_W(2), .BASE_ADDR(24'h000000), .SLOT_STRIDE(24'h060000),
        .READ_MODE(0), .GAP_CYCLES(3), .HOLD_CYCLES(4), .BTN_SLOT(1)
    ) dut1 (
        .CLK(clk), .MBT_RESET(rst), .reboot_req(req[1]), .reboot_slot(slot[1]),
        .btn_n(btn[1]), .busy(busy[1]), .err(err[1]), .icap_ce_n(ce_n[1]),
        .icap_wr_n(wr_n[1]), .icap_i(ii[1])
    );

    function automatic int cfg_mode(input int d);  return (d == 0) ? 2 : 0;  endfunction
    function automatic int cfg_gap(input int d);   return (d == 0) ? 0 : 3;  endfunction
    function automatic int cfg_ns(input int d);    return (d == 0) ? 4 : 3;  endfunction
    function automatic int cfg_hold(input int d);  return (d == 0) ? 16 : 4; endfunction
    function automatic int cfg_bslot(input int d); return (d == 0) ? 0 : 1;  endfunction

    function automatic logic [15:0] rev_bytes(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8 + i] = w[15-i];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Model: each accepted request becomes a timeline anchored at its accept edge.
    int          cyc = 0;
    bit          started = 0;
    int          t0   [2];
    int          endc [2];
    int          nw   [2];
    logic [15:0] wl   [2][16];
    logic [19:0] expv [2];
    bit          b1   [2];
    bit          b2   [2];
    int          run  [2];

    task automatic push_word(input int d, input logic [15:0] w);
        wl[d][nw[d]] = w;
        nw[d]++;
    endtask

    task automatic start_seq(input int d, input int s);
        logic [23:0] a;
        logic [7:0]  op;
        a  = 24'(s * 32'h060000);
        op = (cfg_mode(d) == 2) ? 8'h6B : (cfg_mode(d) == 1) ? 8'h3B : 8'h03;
        nw[d] = 0;
        push_word(d, 16'hAA99); push_word(d, 16'h5566); push_word(d, 16'h30A1); push_word(d, 16'h0000);
        push_word(d, 16'h3261); push_word(d, a[15:0]);
        push_word(d, 16'h3281); push_word(d, {op, a[23:16]});
        if (cfg_mode(d) == 2) begin
            push_word(d, 16'h3301); push_word(d, 16'h3100);
        end
        push_word(d, 16'h30A1); push_word(d, 16'h000E);
        for (int i = 0; i < 4; i++) push_word(d, 16'h2000);
        t0[d]   = cyc;
        endc[d] = cyc + 2 + nw[d] * (1 + cfg_gap(d)) + 1;
    endtask

    task automatic model_step(input int d);
        bit trig;
        bit e_err;
        int per;
        int off;
        if (rst) begin
            endc[d] = -10;
            b1[d] = 1; b2[d] = 1; run[d] = 0;
            expv[d] = {1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF};
            return;
        end
        trig   = b2[d] && (run[d] >= cfg_hold(d));
        run[d] = b2[d] ? 0 : run[d] + 1;
        b2[d]  = b1[d];
        b1[d]  = btn[d];
        e_err  = 0;
        if (cyc > endc[d]) begin
            if (req[d]) begin
                if (int'(slot[d]) < cfg_ns(d)) start_seq(d, int'(slot[d]));
                else e_err = 1;
            end else if (trig) begin
                start_seq(d, cfg_bslot(d));
            end
        end
        per = 1 + cfg_gap(d);
        off = cyc - t0[d] - 2;
        expv[d] = {cyc < endc[d], e_err, 1'b1, 1'b1, 16'hFFFF};
        if (cyc < endc[d] && off >= 0 && off < nw[d] * per && (off % per) == 0)
            expv[d] = {1'b1, e_err, 1'b0, 1'b0, rev_bytes(wl[d][off / per])};
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) started = 1;
        for (int d = 0; d < 2; d++) model_step(d);
    end

    // Per-cycle pin comparison plus a strobe/busy/err recorder for the literal checks.
    logic [15:0] cap [2][64];
    int          ncap [2];
    int          nb   [2];
    int          ne   [2];

    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("pins%0d_c%0d", d, cyc),
                      32'({busy[d], err[d], ce_n[d], wr_n[d], ii[d]}), 32'(expv[d]));
                if (ce_n[d] === 1'b0 && ncap[d] < 64) begin
                    cap[d][ncap[d]] = ii[d];
                    ncap[d]++;
                end
                if (busy[d] === 1'b1) nb[d]++;
                if (err[d] === 1'b1) ne[d]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            ncap[d] = 0; nb[d] = 0; ne[d] = 0;
        end
    endtask

    task automatic pulse_req(input int d, input logic [1:0] s);
        req[d]  = 1'b1;
        slot[d] = s;
        tick(1);
        req[d]  = 1'b0;
    endtask

    logic [15:0] basic_exp [16] = '{16'h5599, 16'hAA66, 16'h0C85, 16'h0000,
                                    16'h4C86, 16'h0000, 16'h4C81, 16'hD630,
                                    16'hCC80, 16'h8C00, 16'h0C85, 16'h0070,
                                    16'h0400, 16'h0400, 16'h0400, 16'h0400};

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; slot[d] = 2'd0; btn[d] = 1'b1;
        end
        clear_mon();
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_busy", 32'(busy[0]), 32'd0);
        check("reset_ce_n", 32'(ce_n[0]), 32'd1);
        check("reset_icap", 32'(ii[0]), 32'hFFFF);

        // Basic 4x reboot, slot 2, contiguous words.
        clear_mon();
        pulse_req(0, 2'd2);
        tick(25);
        check("basic_count", 32'(ncap[0]), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("basic_w%0d", i), 32'(cap[0][i]), 32'(basic_exp[i]));
        check("basic_busy_len", 32'(nb[0]), 32'd19);

        // 1x mode with 3-cycle gaps, slot 1.
        clear_mon();
        pulse_req(1, 2'd1);
        tick(65);
        check("gap_count", 32'(ncap[1]), 32'd14);
        check("gap_w7", 32'(cap[1][7]), 32'hC060);
        check("gap_w8", 32'(cap[1][8]), 32'h0C85);
        check("gap_busy_len", 32'(nb[1]), 32'd59);

        // Invalid slot on the 3-slot instance.
        clear_mon();
        pulse_req(1, 2'd3);
        tick(5);
        check("bad_err_pulses", 32'(ne[1]), 32'd1);
        check("bad_strobes", 32'(ncap[1]), 32'd0);
        check("bad_busy", 32'(nb[1]), 32'd0);

        // Debounce boundary on both instances.
        clear_mon();
        btn[1] = 1'b0; tick(3); btn[1] = 1'b1; tick(10);
        check("btn1_short", 32'(ncap[1]), 32'd0);
        clear_mon();
        btn[1] = 1'b0; tick(4); btn[1] = 1'b1; tick(70);
        check("btn1_hold_count", 32'(ncap[1]), 32'd14);
        check("btn1_hold_w7", 32'(cap[1][7]), 32'hC060);
        clear_mon();
        btn[0] = 1'b0; tick(15); btn[0] = 1'b1; tick(10);
        check("btn0_short", 32'(ncap[0]), 32'd0);
        clear_mon();
        btn[0] = 1'b0; tick(16); btn[0] = 1'b1; tick(25);
        check("btn0_hold_count", 32'(ncap[0]), 32'd16);
        check("btn0_hold_w7", 32'(cap[0][7]), 32'hD600);

        // Request and button trigger land on the same edge: request slot wins.
        clear_mon();
        btn[0] = 1'b0; tick(20); btn[0] = 1'b1; tick(2);
        pulse_req(0, 2'd3);
        tick(30);
        check("contend_count", 32'(ncap[0]), 32'd16);
        check("contend_w7", 32'(cap[0][7]), 32'hD648);

        // Second request mid-sequence is dropped.
        clear_mon();
        pulse_req(0, 2'd1);
        tick(8);
        pulse_req(0, 2'd2);
        tick(25);
        check("midreq_count", 32'(ncap[0]), 32'd16);
        check("midreq_w7", 32'(cap[0][7]), 32'hD660);

        // Reset while word 5 is on the pins, then a fresh request.
        clear_mon();
        pulse_req(0, 2'd0);
        for (int i = 0; i < 30 && ncap[0] < 6; i++) tick(1);
        check("rst_reach_w5", 32'(ncap[0]), 32'd6);
        rst = 1'b1;
        tick(1);
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        check("rst_mid_ce_n", 32'(ce_n[0]), 32'd1);
        check("rst_mid_icap", 32'(ii[0]), 32'hFFFF);
        rst = 1'b0;
        tick(2);
        clear_mon();
        pulse_req(0, 2'd2);
        tick(25);
        check("restart_count", 32'(ncap[0]), 32'd16);
        check("restart_w0", 32'(cap[0][0]), 32'h5599);
        check("restart_w7", 32'(cap[0][7]), 32'hD630);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
